// File: rtl/tnn_csr_encoder_if.sv
// Handshake bundle between the weight-loading path, the CSR encoder and the CSR weight store.
// The master modport is the loader/store side; the slave modport is the encoder.
interface tnn_csr_encoder_if #(
    parameter int unsigned ROW_CNT = 7,
    parameter int unsigned COL_CNT = 40
);
    localparam int unsigned COL_BITS = (COL_CNT > 1) ? $clog2(COL_CNT) : 1;
    localparam int unsigned ROW_BITS = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
    localparam int unsigned PTR_W    = $clog2(ROW_CNT * COL_CNT + 1);

    logic                           start;
    logic                           in_valid;
    logic                           in_ready;
    logic [COL_CNT-1:0]             in_mask;
    logic [COL_CNT-1:0]             in_sign;
    logic                           e_valid;
    logic                           e_ready;
    logic [COL_BITS-1:0]            e_col;
    logic                           e_val;
    logic [ROW_BITS-1:0]            e_row;
    logic                           e_row_end;
    logic [(ROW_CNT+1)*PTR_W-1:0]   row_ptrs;
    logic [PTR_W-1:0]               nz_cnt;
    logic                           done;

    modport master (
        output start, in_valid, in_mask, in_sign, e_ready,
        input  in_ready, e_valid, e_col, e_val, e_row, e_row_end, row_ptrs, nz_cnt, done
    );

    modport slave (
        input  start, in_valid, in_mask, in_sign, e_ready,
        output in_ready, e_valid, e_col, e_val, e_row, e_row_end, row_ptrs, nz_cnt, done
    );
endinterface

// File: rtl/tnn_csr_encoder.sv
// Dense ternary row -> CSR encoder: emits (col, sign) per non-zero weight in row-major,
// ascending-column order and builds the per-row start pointer table.
module tnn_csr_encoder #(
    parameter int unsigned ROW_CNT = 7,
    parameter int unsigned COL_CNT = 40
) (
    input logic              clk,
    input logic              rst,
    tnn_csr_encoder_if.slave bus
);
    localparam int unsigned COL_BITS = (COL_CNT > 1) ? $clog2(COL_CNT) : 1;
    localparam int unsigned ROW_BITS = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
    localparam int unsigned PTR_W    = $clog2(ROW_CNT * COL_CNT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StScan,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_CNT-1:0]  rem_mask_q, rem_mask_d;
    logic [COL_CNT-1:0]  sign_q, sign_d;
    logic [PTR_W-1:0]    nz_cnt_q, nz_cnt_d;
    // ptr_q[r] holds row_ptrs entry r+1; entry 0 is the constant zero.
    logic [PTR_W-1:0]    ptr_q [ROW_CNT];
    logic [PTR_W-1:0]    ptr_d [ROW_CNT];

    logic [COL_BITS-1:0] scan_col;
    logic [COL_CNT-1:0]  rem_mask_rest;
    logic                last_bit;
    logic                last_row;

    // Lowest set bit of the remaining mask selects the entry to present.
    always_comb begin
        scan_col = '0;
        for (int c = COL_CNT - 1; c >= 0; c--) begin
            if (rem_mask_q[c]) begin
                scan_col = COL_BITS'(c);
            end
        end
    end

    assign rem_mask_rest = rem_mask_q & (rem_mask_q - COL_CNT'(1));
    assign last_bit      = (rem_mask_rest == '0);
    assign last_row      = (row_q == ROW_BITS'(ROW_CNT - 1));

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        rem_mask_d = rem_mask_q;
        sign_d     = sign_q;
        nz_cnt_d   = nz_cnt_q;
        for (int r = 0; r < ROW_CNT; r++) begin
            ptr_d[r] = ptr_q[r];
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d    = StAccept;
                    row_d      = '0;
                    nz_cnt_d   = '0;
                    rem_mask_d = '0;
                    sign_d     = '0;
                    for (int r = 0; r < ROW_CNT; r++) begin
                        ptr_d[r] = '0;
                    end
                end
            end
            StAccept: begin
                if (bus.in_valid) begin
                    rem_mask_d = bus.in_mask;
                    // Signs under zero mask bits are dropped so they can never leak out.
                    sign_d     = bus.in_sign & bus.in_mask;
                    if (bus.in_mask == '0) begin
                        ptr_d[row_q] = nz_cnt_q;
                        row_d        = row_q + 1'b1;
                        if (last_row) begin
                            state_d = StDone;
                        end
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                if (bus.e_ready) begin
                    rem_mask_d = rem_mask_rest;
                    nz_cnt_d   = nz_cnt_q + 1'b1;
                    if (last_bit) begin
                        ptr_d[row_q] = nz_cnt_q + 1'b1;
                        row_d        = row_q + 1'b1;
                        state_d      = last_row ? StDone : StAccept;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StAccept);
        bus.e_valid   = (state_q == StScan);
        bus.done      = (state_q == StDone);
        bus.nz_cnt    = nz_cnt_q;
        bus.e_col     = '0;
        bus.e_val     = 1'b0;
        bus.e_row     = '0;
        bus.e_row_end = 1'b0;
        if (state_q == StScan) begin
            bus.e_col     = scan_col;
            bus.e_val     = sign_q[scan_col];
            bus.e_row     = row_q;
            bus.e_row_end = last_bit;
        end
        bus.row_ptrs = '0;
        for (int r = 0; r < ROW_CNT; r++) begin
            bus.row_ptrs[(r+1)*PTR_W +: PTR_W] = ptr_q[r];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            rem_mask_q <= '0;
            sign_q     <= '0;
            nz_cnt_q   <= '0;
            for (int r = 0; r < ROW_CNT; r++) begin
                ptr_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            rem_mask_q <= rem_mask_d;
            sign_q     <= sign_d;
            nz_cnt_q   <= nz_cnt_d;
            for (int r = 0; r < ROW_CNT; r++) begin
                ptr_q[r] <= ptr_d[r];
            end
        end
    end

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst)
        !(bus.in_ready && bus.e_valid));

    a_nz_bound: assert property (@(posedge clk) disable iff (!rst)
        nz_cnt_q <= PTR_W'(ROW_CNT * COL_CNT));
endmodule

// File: doc/tnn_csr_encoder.md
# tnn_csr_encoder

Streaming encoder that turns dense ternary weight rows into the compressed-sparse-row form consumed by the sequential TNN cores. It produces one sign bit and one column index per non-zero weight, plus the per-row start pointer table. It sits between the weight-loading path, which supplies one row per handshake as a nonzero mask and a sign vector, and the CSR weight store that the inference core reads.

## Interface
- ROW_CNT, 7, number of rows (output classes)
- COL_CNT, 40, columns per row (hidden neurons)
- localparam COL_BITS = $clog2(COL_CNT); ROW_BITS = $clog2(ROW_CNT); PTR_W = $clog2(ROW_CNT*COL_CNT+1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new matrix (honoured in IDLE and DONE only)
- in_valid  in  1  row data valid
- in_ready  out  1  block accepts a row this cycle
- in_mask  in  COL_CNT  bit c=1: weight (row,c) is non-zero
- in_sign  in  COL_CNT  bit c=1: +1, 0: -1 (ignored where mask=0)
- e_valid  out  1  non-zero entry valid
- e_ready  in  1  downstream accepts entry
- e_col  out  COL_BITS  column index of entry
- e_val  out  1  sign bit of entry (1 = +1)
- e_row  out  ROW_BITS  row of entry
- e_row_end  out  1  entry is last non-zero of its row
- row_ptrs  out  (ROW_CNT+1)*PTR_W  start pointers; entry r at bits [r*PTR_W +: PTR_W]; entry 0 always 0
- nz_cnt  out  PTR_W  non-zeros emitted so far
- done  out  1  full matrix encoded

## Operation
- States: IDLE, ACCEPT, SCAN, DONE. Reset → IDLE.
- IDLE and DONE: start → clear row counter, nz_cnt, and all row_ptrs; done←0; go to ACCEPT. start is ignored in ACCEPT and SCAN.
- ACCEPT: in_ready=1. On in_valid, latch in_mask into rem_mask and in_sign into sign_reg.
  - If in_mask==0: row_ptrs[row+1]←nz_cnt, row++. If that was row ROW_CNT-1, go to DONE; otherwise stay in ACCEPT.
  - Otherwise go to SCAN.
- SCAN: e_valid=1. e_col = index of the lowest set bit of rem_mask. e_val = sign_reg[e_col]. e_row = row. e_row_end = (rem_mask has exactly one bit set).
  - On e_ready: clear that bit and nz_cnt++.
  - If it was the last bit: row_ptrs[row+1]←nz_cnt+1, row++. Go to DONE if it was row ROW_CNT-1, else to ACCEPT.
- Entries leave in ascending column order within a row and ascending row order overall. This matches the COL_INDICES / SPARSE_VALS2 ordering.
- DONE: done=1, in_ready=0, e_valid=0. Outputs hold until start or reset.
- Arithmetic: nz_cnt and the pointers are unsigned PTR_W-bit values and cannot overflow, since the maximum is ROW_CNT*COL_CNT.
- Mask bits at positions ≥ COL_CNT do not exist. Sign bits under zero mask bits never appear on any output.

## Timing
- Reset values: in_ready 0, e_valid 0, e_col 0, e_val 0, e_row 0, e_row_end 0, row_ptrs all 0, nz_cnt 0, done 0, state IDLE.
- start at cycle T → in_ready=1 from T+1.
- A row with k>0 non-zeros accepted at edge N, with e_ready held high:
  - entries are presented in cycles N+1..N+k, one per cycle;
  - in_ready=1 again in cycle N+k+1.
- An empty row costs one cycle. in_ready stays high, so back-to-back empty rows are accepted on consecutive cycles.
- Backpressure: while e_valid && !e_ready, e_col, e_val, e_row and e_row_end hold stable and no state advances.
- row_ptrs[r+1] and nz_cnt update on the same edge that completes row r.
- done rises the cycle after the final row completes.
- in_ready and e_valid are never both 1.
- Asynchronous reset mid-row discards partial state. There is no output glitch requirement beyond reaching the reset values.

## Test plan
- Single row, defaults: start; row 0 mask bits {1,4,6}, sign {1:+,4:-,6:+} → entries (col,val,row_end) = (1,1,0), (4,0,0), (6,1,1) on three consecutive cycles; row_ptrs[1]=3; nz_cnt=3.
- Empty rows: rows 0–6 all mask=0 → seven accepts on seven consecutive cycles, no e_valid, all row_ptrs=0, done=1 the cycle after the last accept.
- Full row: row 0 mask all 40 ones, sign alternating starting with + → 40 entries, cols 0..39, e_val 1,0,1,…, row_end only on col 39, row_ptrs[1]=40.
- Backpressure: 3-entry row with e_ready low for 5 cycles on the second entry → col 4 held stable for 5 cycles, no duplicate or lost entries, nz_cnt=3 at row end.
- Full matrix: seven rows with non-zero counts 6,9,5,6,7,8,15 → row_ptrs = 0,6,15,20,26,33,41,56 and done=1. A start in DONE clears row_ptrs to 0 and restarts.
- Reset mid-SCAN: assert rst during the second entry → all outputs at reset values immediately; after release, state is IDLE and start is required.
